// File: rtl/msg_arb_pkg.sv
// Shared definitions for the message read arbiter: FSM encoding, width defaults
// and the round-robin pointer advance helper.
package msg_arb_pkg;

  localparam int CH_W       = 3;
  localparam int MAX_CH     = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_REQ = 3'd1,
    S_LEN_CAP = 3'd2,
    S_RD      = 3'd3,
    S_CAP     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] idx, input int n_ch);
    logic [CH_W-1:0] nxt;
    if (int'(idx) >= n_ch - 1) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/msg_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr,
// wrapping modulo N_CH.
module rr_arbiter
  import msg_arb_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  localparam int PW = CH_W + 1;

  logic [MAX_CH-1:0] req_pad;
  logic [PW-1:0]     pos;
  logic [CH_W-1:0]   sel;

  assign req_pad = MAX_CH'(req);

  // Scan channels in priority order starting from the pointer
  always_comb begin
    idx   = 3'd0;
    any   = 1'b0;
    pos   = '0;
    sel   = 3'd0;
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      sel = (pos >= PW'(N_CH)) ? (pos[CH_W-1:0] - CH_W'(N_CH)) : pos[CH_W-1:0];
      if (!any && req_pad[sel]) begin
        idx = sel;
        any = 1'b1;
      end else begin
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      grant[j] = any && (idx == CH_W'(j));
    end
  end

endmodule

// File: rtl/msg_read_arbiter.sv
// Round-robin reader draining whole messages from N_CH length/data FIFO pairs
// onto one valid/ready stream. Define MSG_STATS_EN to add MSG_CNT/DROP_CNT.
module msg_read_arbiter
  import msg_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                   SYS_CLK,
  input  logic                   RST,
  input  logic [N_CH-1:0]        GOT_FULL_MSG,
  input  logic [N_CH*LEN_W-1:0]  MSG_LEN,
  input  logic [N_CH*DATA_W-1:0] FIFO_Q,
  output logic [N_CH-1:0]        RD_REQ_LEN,
  output logic [N_CH-1:0]        RD_REQ,
  output logic [DATA_W-1:0]      OUT_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   OUT_SOP,
  output logic                   OUT_EOP,
  output logic [CH_W-1:0]        OUT_CH,
`ifdef MSG_STATS_EN
  output logic [15:0]            MSG_CNT,
  output logic [7:0]             DROP_CNT,
`endif
  output logic                   BUSY
);

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic [N_CH-1:0]   grant_oh;
  logic [LEN_W-1:0]  remaining;
  logic              first_word;

  logic [N_CH-1:0]   arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  // Padded to 8 entries so a 3-bit channel index selects without width mismatch
  logic [LEN_W-1:0]  len_arr [MAX_CH];
  logic [DATA_W-1:0] q_arr   [MAX_CH];

  for (genvar g = 0; g < MAX_CH; g++) begin : g_unpack
    if (g < N_CH) begin : g_on
      assign len_arr[g] = MSG_LEN[g*LEN_W +: LEN_W];
      assign q_arr[g]   = FIFO_Q[g*DATA_W +: DATA_W];
    end else begin : g_off
      assign len_arr[g] = '0;
      assign q_arr[g]   = '0;
    end
  end

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req   (GOT_FULL_MSG),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Message scheduler FSM with all outputs registered
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      rr_ptr     <= 3'd0;
      grant_idx  <= 3'd0;
      grant_oh   <= '0;
      remaining  <= '0;
      first_word <= 1'b0;
      RD_REQ_LEN <= '0;
      RD_REQ     <= '0;
      OUT_DATA   <= '0;
      OUT_VALID  <= 1'b0;
      OUT_SOP    <= 1'b0;
      OUT_EOP    <= 1'b0;
      OUT_CH     <= 3'd0;
      BUSY       <= 1'b0;
`ifdef MSG_STATS_EN
      MSG_CNT    <= 16'd0;
      DROP_CNT   <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            grant_idx  <= arb_idx;
            grant_oh   <= arb_grant;
            RD_REQ_LEN <= arb_grant;
            BUSY       <= 1'b1;
            state      <= S_LEN_REQ;
          end else begin
            BUSY <= 1'b0;
          end
        end
        S_LEN_REQ: begin
          RD_REQ_LEN <= '0;
          state      <= S_LEN_CAP;
        end
        S_LEN_CAP: begin
          remaining  <= len_arr[grant_idx];
          first_word <= 1'b1;
          if (len_arr[grant_idx] == '0) begin
            // A dropped message still counts as this channel's turn
            rr_ptr <= next_ptr(grant_idx, N_CH);
            BUSY   <= 1'b0;
            state  <= S_IDLE;
`ifdef MSG_STATS_EN
            if (DROP_CNT != 8'hFF) begin
              DROP_CNT <= DROP_CNT + 8'd1;
            end else begin
              DROP_CNT <= DROP_CNT;
            end
`endif
          end else begin
            RD_REQ <= grant_oh;
            state  <= S_RD;
          end
        end
        S_RD: begin
          RD_REQ <= '0;
          state  <= S_CAP;
        end
        S_CAP: begin
          OUT_DATA  <= q_arr[grant_idx];
          OUT_VALID <= 1'b1;
          OUT_SOP   <= first_word;
          OUT_EOP   <= (remaining == LEN_W'(1));
          OUT_CH    <= grant_idx;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (OUT_READY) begin
            OUT_VALID  <= 1'b0;
            OUT_SOP    <= 1'b0;
            OUT_EOP    <= 1'b0;
            first_word <= 1'b0;
            remaining  <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              rr_ptr <= next_ptr(grant_idx, N_CH);
              BUSY   <= 1'b0;
              state  <= S_IDLE;
`ifdef MSG_STATS_EN
              MSG_CNT <= MSG_CNT + 16'd1;
`endif
            end else begin
              RD_REQ <= grant_oh;
              state  <= S_RD;
            end
          end else begin
            state <= S_HOLD;
          end
        end
        default: begin
          RD_REQ_LEN <= '0;
          RD_REQ     <= '0;
          OUT_VALID  <= 1'b0;
          BUSY       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_read_arbiter.sv
// Scoreboard bench for msg_read_arbiter: FIFO models, a round-robin reference
// model over per-channel message lists, and a monitor checking the stream.
module tb_msg_read_arbiter;

  localparam int N_CH = 4;
  localparam int DW   = 16;
  localparam int LW   = 8;

  logic             SYS_CLK = 1'b0;
  logic             RST = 1'b0;
  logic [N_CH-1:0]  GOT_FULL_MSG = '0;
  logic [N_CH*LW-1:0] MSG_LEN = '0;
  logic [N_CH*DW-1:0] FIFO_Q = '0;
  logic [N_CH-1:0]  RD_REQ_LEN, RD_REQ;
  logic [DW-1:0]    OUT_DATA;
  logic             OUT_VALID, OUT_SOP, OUT_EOP, BUSY;
  logic             OUT_READY = 1'b1;
  logic [2:0]       OUT_CH;
`ifdef MSG_STATS_EN
  logic [15:0]      MSG_CNT;
  logic [7:0]       DROP_CNT;
`endif

  msg_read_arbiter #(.N_CH(N_CH), .DATA_W(DW), .LEN_W(LW)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_MSG(GOT_FULL_MSG), .MSG_LEN(MSG_LEN),
    .FIFO_Q(FIFO_Q), .RD_REQ_LEN(RD_REQ_LEN), .RD_REQ(RD_REQ), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SOP(OUT_SOP), .OUT_EOP(OUT_EOP),
    .OUT_CH(OUT_CH),
`ifdef MSG_STATS_EN
    .MSG_CNT(MSG_CNT), .DROP_CNT(DROP_CNT),
`endif
    .BUSY(BUSY));

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct { logic [15:0] d; logic sop; logic eop; logic [2:0] ch; } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fifo_dat[N_CH][$];
  int          fifo_len[N_CH][$];
  logic [15:0] pend_dat[N_CH][$];
  int          pend_len[N_CH][$];

  int m_ptr = 0;
  int n_chk = 0, n_pass = 0;
  int exp_words = 0, exp_msgs = 0, exp_done = 0, exp_drops = 0;
  int obs_rd = 0, obs_len = 0, viol = 0, acc_total = 0, sop_cnt = 0;
  int stall_left = 0;
  bit rand_ready = 0, stall_on_sop = 0, stall_pend = 0;
  logic [31:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic void update_gfm();
    for (int c = 0; c < N_CH; c++) GOT_FULL_MSG[c] = (fifo_len[c].size() != 0);
  endfunction

  function automatic bit lens_empty();
    bit e = 1;
    for (int c = 0; c < N_CH; c++) if (fifo_len[c].size() != 0) e = 0;
    return e;
  endfunction

  task automatic add_msg(input int ch, input int len);
    logic [15:0] d;
    for (int i = 0; i < len; i++) begin
      d = 16'($urandom);
      fifo_dat[ch].push_back(d);
      pend_dat[ch].push_back(d);
    end
    fifo_len[ch].push_back(len);
    pend_len[ch].push_back(len);
    update_gfm();
  endtask

  // Reference: serve pending messages round-robin, whole message per turn
  function automatic void run_model();
    int c, len;
    bit found;
    exp_t e;
    do begin
      found = 0;
      c = 0;
      for (int k = 0; k < N_CH; k++)
        if (!found && pend_len[(m_ptr + k) % N_CH].size() != 0) begin
          c = (m_ptr + k) % N_CH;
          found = 1;
        end
      if (found) begin
        len = pend_len[c].pop_front();
        for (int w = 0; w < len; w++) begin
          e.d = pend_dat[c].pop_front();
          e.sop = (w == 0);
          e.eop = (w == len - 1);
          e.ch = 3'(c);
          exp_q.push_back(e);
        end
        exp_words += len;
        exp_msgs++;
        if (len == 0) exp_drops++; else exp_done++;
        m_ptr = (c + 1) % N_CH;
      end
    end while (found);
  endfunction

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (t < budget && !(exp_q.size() == 0 && !BUSY && lens_empty())) begin
      tick();
      t++;
    end
    if (t >= budget) begin
      n_chk++;
      $display("FAIL %s_timeout: got %0d words outstanding, required 0", name, exp_q.size());
    end
    repeat (3) tick();
    chk({name, "_rd_req"}, obs_rd, exp_words);
    chk({name, "_rd_req_len"}, obs_len, exp_msgs);
    chk({name, "_busy"}, {31'd0, BUSY}, 32'd0);
`ifdef MSG_STATS_EN
    chk({name, "_msg_cnt"}, {16'd0, MSG_CNT}, 32'(exp_done & 16'hFFFF));
    chk({name, "_drop_cnt"}, {24'd0, DROP_CNT}, (exp_drops > 255) ? 32'd255 : 32'(exp_drops));
`endif
  endtask

  // Length/data FIFO models: pop one entry per request bit, q valid afterwards
  initial forever begin
    tick();
    if (RST) begin
      for (int c = 0; c < N_CH; c++) begin
        if (RD_REQ_LEN[c]) begin
          if (fifo_len[c].size() == 0) viol++;
          else MSG_LEN[c*LW +: LW] = LW'(fifo_len[c].pop_front());
        end
        if (RD_REQ[c]) begin
          if (fifo_dat[c].size() == 0) viol++;
          else FIFO_Q[c*DW +: DW] = fifo_dat[c].pop_front();
        end
      end
      update_gfm();
    end
  end

  initial forever begin
    tick();
    if (stall_left > 0) begin
      OUT_READY = 1'b0;
      stall_left--;
    end else if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
    else OUT_READY = 1'b1;
  end

  // Monitor: request legality, stall stability, accepted words vs scoreboard
  initial forever begin
    exp_t e;
    @(negedge SYS_CLK);
    if (!RST) stall_pend = 0;
    else begin
      obs_rd  += $countones(RD_REQ);
      obs_len += $countones(RD_REQ_LEN);
      if ($countones(RD_REQ) > 1 || $countones(RD_REQ_LEN) > 1 || (RD_REQ != '0 && RD_REQ_LEN != '0)) viol++;
      if (stall_pend) chk("hold_stable", {10'd0, OUT_VALID, OUT_SOP, OUT_EOP, OUT_CH, OUT_DATA}, held);
      stall_pend = OUT_VALID && !OUT_READY;
      held = {10'd0, OUT_VALID, OUT_SOP, OUT_EOP, OUT_CH, OUT_DATA};
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_word: got ch %0d data 0x%0h, required no word", OUT_CH, OUT_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {13'd0, OUT_SOP, OUT_EOP, OUT_CH, OUT_DATA}, {13'd0, e.sop, e.eop, e.ch, e.d});
        end
        acc_total++;
        if (OUT_SOP) sop_cnt++;
        if (stall_on_sop && OUT_SOP) begin
          stall_left = 5;
          stall_on_sop = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, t;
    repeat (3) tick();
    chk("reset_outputs", {8'd0, OUT_VALID, OUT_SOP, OUT_EOP, BUSY, OUT_CH, RD_REQ, RD_REQ_LEN},
        32'd0);
    chk("reset_data", {16'd0, OUT_DATA}, 32'd0);
    RST = 1'b1;
    tick();

    add_msg(1, 3);
    run_model();
    wait_idle("ch1_len3", 200);

    add_msg(3, 0);
    run_model();
    wait_idle("ch3_len0", 200);

    // ch0 and ch2 together; a second ch0 message arrives while the first drains
    base = sop_cnt;
    add_msg(0, 3);
    add_msg(2, 2);
    run_model();
    t = 0;
    while (t < 200 && sop_cnt == base) begin tick(); t++; end
    add_msg(0, 2);
    run_model();
    wait_idle("rr_order", 400);

    stall_on_sop = 1;
    add_msg(1, 4);
    run_model();
    wait_idle("stall", 300);

    add_msg(0, 255);
    run_model();
    wait_idle("len255", 2000);

    rand_ready = 1;
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) add_msg($urandom_range(0, N_CH - 1), $urandom_range(0, 8));
      run_model();
      wait_idle("random", 3000);
    end
    rand_ready = 0;

    // Reset while word 4 of 10 is on the output
    add_msg(1, 10);
    run_model();
    base = acc_total;
    t = 0;
    while (t < 300 && !(acc_total >= base + 3 && OUT_VALID)) begin tick(); t++; end
    RST = 1'b0;
    #1;
    chk("midrst_outputs", {8'd0, OUT_VALID, OUT_SOP, OUT_EOP, BUSY, OUT_CH, RD_REQ, RD_REQ_LEN},
        32'd0);
    chk("midrst_words_before", acc_total - base, 32'd3);
    for (int c = 0; c < N_CH; c++) begin
      fifo_dat[c].delete();
      fifo_len[c].delete();
      pend_dat[c].delete();
      pend_len[c].delete();
    end
    exp_q.delete();
    m_ptr = 0;
    exp_words = 0; exp_msgs = 0; exp_done = 0; exp_drops = 0;
    obs_rd = 0; obs_len = 0;
    MSG_LEN = '0;
    FIFO_Q = '0;
    update_gfm();
    repeat (3) tick();
    RST = 1'b1;
    tick();
    add_msg(2, 3);
    run_model();
    wait_idle("after_rst", 200);

    chk("req_legality", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
